// File: rtl/wide_add_slice_seq_pkg.sv
// ---------------------------------------------------------------------------
// wide_add_slice_seq_pkg
//   Shared constants and types for the sliced wide-adder family.
//   ADD_SLICE_W : width of the combinational prefix adder (one slice).
//   ADD_NSLICE  : default number of slices per wide operation.
//   ADD_WIDE_W  : resulting default operand width.
//   seq_state_e : sequencer control states.
// ---------------------------------------------------------------------------
package wide_add_slice_seq_pkg;

  localparam int unsigned ADD_SLICE_W = 30;
  localparam int unsigned ADD_NSLICE  = 3;
  localparam int unsigned ADD_WIDE_W  = ADD_SLICE_W * ADD_NSLICE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/wide_add_slice_seq.sv
// ---------------------------------------------------------------------------
// wide_add_slice_seq
//   Performs one SLICE_W*NSLICE-bit addition by streaming SLICE_W-bit slices,
//   LSB slice first, through an external combinational SLICE_W-bit adder.
//   The slice carry is held in a register between cycles, so the external
//   adder is the only arithmetic in the path.
//
// Ports
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_valid/in_ready   : operand beat handshake
//   in_a, in_b, in_cin  : wide operands and carry-in
//   out_valid/out_ready : result handshake
//   out_sum, out_cout   : wide sum and carry-out of the top slice
//   add_a, add_b, add_cin : drive to the external slice adder (zero when idle)
//   add_sum, add_cout   : result from the external slice adder
// ---------------------------------------------------------------------------
module wide_add_slice_seq
  import wide_add_slice_seq_pkg::*;
#(
  parameter int unsigned SLICE_W = ADD_SLICE_W,
  parameter int unsigned NSLICE  = ADD_NSLICE,
  parameter int unsigned IDX_W   = $clog2(NSLICE)
) (
  input  logic                        clk,
  input  logic                        rst_n,

  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [SLICE_W*NSLICE-1:0]   in_a,
  input  logic [SLICE_W*NSLICE-1:0]   in_b,
  input  logic                        in_cin,

  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [SLICE_W*NSLICE-1:0]   out_sum,
  output logic                        out_cout,

  output logic [SLICE_W-1:0]          add_a,
  output logic [SLICE_W-1:0]          add_b,
  output logic                        add_cin,
  input  logic [SLICE_W-1:0]          add_sum,
  input  logic                        add_cout
);

  localparam int unsigned WW    = SLICE_W * NSLICE;
  // Only the lower slices need holding; the top slice goes straight from
  // add_sum into the output register on the final cycle.
  localparam int unsigned LOW_W = SLICE_W * (NSLICE - 1);

  seq_state_e         state_q, state_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic               carry_q, carry_d;
  logic [WW-1:0]      opa_q,   opa_d;
  logic [WW-1:0]      opb_q,   opb_d;
  logic [LOW_W-1:0]   res_q,   res_d;
  logic [WW-1:0]      sum_q,   sum_d;
  logic               cout_q,  cout_d;

  logic               accept;
  logic               last_slice;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  // A new beat may be taken while the previous result leaves on the same edge.
  assign in_ready   = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept     = in_valid & in_ready;
  assign last_slice = (idx_q == IDX_W'(NSLICE - 1));

  assign out_valid  = (state_q == DONE);
  assign out_sum    = sum_q;
  assign out_cout   = cout_q;

  // ---------------------------------------------------------------------------
  // Slice mux towards the external adder; quiet outside RUN
  // ---------------------------------------------------------------------------
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state_q == RUN) begin
      add_cin = carry_q;
      for (int unsigned s = 0; s < NSLICE; s++) begin
        if (idx_q == IDX_W'(s)) begin
          add_a = opa_q[s*SLICE_W +: SLICE_W];
          add_b = opb_q[s*SLICE_W +: SLICE_W];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          opa_d   = in_a;
          opb_d   = in_b;
          carry_d = in_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        carry_d = add_cout;
        for (int unsigned s = 0; s < NSLICE - 1; s++) begin
          if (idx_q == IDX_W'(s)) begin
            res_d[s*SLICE_W +: SLICE_W] = add_sum;
          end
        end
        if (last_slice) begin
          sum_d   = {add_sum, res_q};
          cout_d  = add_cout;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          if (accept) begin
            opa_d   = in_a;
            opb_d   = in_b;
            carry_d = in_cin;
            idx_d   = '0;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

endmodule

// File: tb/tb_wide_add_slice_seq.sv
module tb_wide_add_slice_seq;

  localparam int unsigned SW  = 30;
  localparam int unsigned NS  = 3;
  localparam int unsigned WW  = SW * NS;
  localparam int unsigned LAT = 3;

  typedef logic [WW:0] v_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [WW-1:0] in_a;
  logic [WW-1:0] in_b;
  logic          in_cin;
  logic          out_valid;
  logic          out_ready;
  logic [WW-1:0] out_sum;
  logic          out_cout;
  logic [SW-1:0] add_a;
  logic [SW-1:0] add_b;
  logic          add_cin;
  logic [SW-1:0] add_sum;
  logic          add_cout;

  always #5 clk = ~clk;

  // Stand-in for the external 30-bit adder
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{SW{1'b0}}, add_cin};

  wide_add_slice_seq #(
    .SLICE_W (SW),
    .NSLICE  (NS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout)
  );

  typedef struct {
    logic [WW-1:0] sum;
    logic          cout;
    int unsigned   acc;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;
  bit          rnd   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input v_t act, input v_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic monitor();
    bit   prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
      end else begin
        if (out_valid && !prev_v) begin
          if (sb.size() == 0) chk("stale_valid", v_t'(out_valid), v_t'(0));
          else                chk("latency", v_t'(cyc - sb[0].acc), v_t'(LAT));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("extra_result", v_t'(out_valid), v_t'(0));
          end else begin
            e = sb.pop_front();
            chk("sum",  v_t'(out_sum),  v_t'(e.sum));
            chk("cout", v_t'(out_cout), v_t'(e.cout));
          end
        end
        prev_v = out_valid;
      end
    end
  endtask

  task automatic send(input logic [WW-1:0] a, input logic [WW-1:0] b, input logic c,
                      input logic [WW-1:0] es, input logic ec, input bit push);
    bit   ok;
    exp_t e;
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        if (push) begin
          e.sum = es; e.cout = ec; e.acc = cyc + 1;
          sb.push_back(e);
        end
        break;
      end
      tick();
    end
    chk("accept", v_t'(ok), v_t'(1));
    tick();
    in_valid = 1'b0;
  endtask

  // Called right after an accept: samples the three slice cycles.
  task automatic chk_cin(input bit c0, input bit c1, input bit c2);
    bit [2:0] e;
    e = {c2, c1, c0};
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("add_cin",   v_t'(add_cin),  v_t'(e[s]));
      chk("ready_run", v_t'(in_ready), v_t'(0));
    end
    tick();
  endtask

  task automatic drain();
    for (int t = 0; t < 2000; t++) begin
      if (sb.size() == 0) break;
      tick();
    end
    chk("drain_empty", v_t'(sb.size()), v_t'(0));
  endtask

  function automatic logic [WW-1:0] rnd_op();
    logic [WW-1:0] v;
    logic [SW-1:0] sl;
    int unsigned   m;
    v = '0;
    m = $urandom_range(0, 3);
    for (int s = 0; s < NS; s++) begin
      case (m)
        0:       sl = SW'($urandom);
        1:       sl = '1;
        2:       sl = ($urandom_range(0, 1) != 0) ? '1 : '0;
        default: sl = SW'($urandom_range(0, 3));
      endcase
      v[s*SW +: SW] = sl;
    end
    return v;
  endfunction

  initial begin
    logic [WW-1:0] a, b;
    logic          c;
    logic [WW:0]   full;
    bit            seen;

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b1;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_valid", v_t'(out_valid), v_t'(0));
    chk("rst_out_sum",   v_t'(out_sum),   v_t'(0));
    chk("rst_out_cout",  v_t'(out_cout),  v_t'(0));
    chk("rst_add_a",     v_t'(add_a),     v_t'(0));
    chk("rst_in_ready",  v_t'(in_ready),  v_t'(1));
    rst_n = 1'b1;
    tick();

    // Simple add
    send(90'd1, 90'd2, 1'b0, 90'd3, 1'b0, 1'b1);
    chk_cin(1'b0, 1'b0, 1'b0);
    // Carry out of slice 0 into slice 1
    send(90'h3FFF_FFFF, 90'd1, 1'b0, 90'h4000_0000, 1'b0, 1'b1);
    chk_cin(1'b0, 1'b1, 1'b0);
    // Carry through every slice
    send({WW{1'b1}}, 90'd0, 1'b1, 90'd0, 1'b1, 1'b1);
    chk_cin(1'b1, 1'b1, 1'b1);
    drain();

    // Backpressure then simultaneous consume + accept
    out_ready = 1'b0;
    send(90'd100, 90'd23, 1'b1, 90'd124, 1'b0, 1'b1);
    seen = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1'b1; break; end
    end
    chk("bp_valid_seen", v_t'(seen), v_t'(1));
    for (int k = 0; k < 5; k++) begin
      chk("bp_sum",      v_t'(out_sum),   v_t'(124));
      chk("bp_cout",     v_t'(out_cout),  v_t'(0));
      chk("bp_in_ready", v_t'(in_ready),  v_t'(0));
      chk("bp_valid",    v_t'(out_valid), v_t'(1));
      @(negedge clk);
    end
    tick();
    out_ready = 1'b1;
    send(90'd1 << 60, 90'd1 << 60, 1'b0, 90'd1 << 61, 1'b0, 1'b1);
    send(90'd1 << 89, 90'd1 << 89, 1'b0, 90'd0, 1'b1, 1'b1);
    drain();

    // Reset in the middle of an operation
    send({30'd7, 30'd5, 30'd3}, {30'd1, 30'd1, 30'd1}, 1'b0, 90'd0, 1'b0, 1'b0);
    tick();
    #1;
    chk("mid_add_a",   v_t'(add_a),   v_t'(5));
    chk("mid_add_b",   v_t'(add_b),   v_t'(1));
    chk("mid_add_cin", v_t'(add_cin), v_t'(0));
    rst_n = 1'b0;
    #1;
    chk("rr_out_valid", v_t'(out_valid), v_t'(0));
    chk("rr_add_a",     v_t'(add_a),     v_t'(0));
    chk("rr_add_b",     v_t'(add_b),     v_t'(0));
    chk("rr_add_cin",   v_t'(add_cin),   v_t'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rr_in_ready", v_t'(in_ready), v_t'(1));
    repeat (6) tick();
    chk("rr_no_stale", v_t'(out_valid), v_t'(0));
    chk("rr_out_sum",  v_t'(out_sum),   v_t'(0));

    // Random traffic with stalls on both sides
    rnd = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      a = rnd_op();
      b = rnd_op();
      c = 1'($urandom_range(0, 1));
      full = {1'b0, a} + {1'b0, b} + {{WW{1'b0}}, c};
      send(a, b, c, full[WW-1:0], full[WW], 1'b1);
    end
    drain();
    rnd = 1'b0;
    out_ready = 1'b1;
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
